instruction_memory_loader: RTL and testbench

- Parametrised program memory for the pipeline's IF stage.
- Adds an in-system byte-serial load path fed by the debug unit (UART RX bytes). Bytes are assembled into words, written at an auto-incrementing address, and loading stops on a HALT word or when memory is full.
- Fetch port gives one-cycle registered reads, with stall (hold) and flush (NOP) control from the hazard unit.

---
 rtl/instruction_memory_loader_if.sv | 31 +++
 rtl/instruction_memory_loader.sv | 102 ++++++++++
 tb/tb_instruction_memory_loader.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_memory_loader_if.sv
// Fetch, byte-load and status signals between the debug/IF/hazard side
// (master) and the instruction memory loader (slave).
interface instruction_memory_loader_if #(
  parameter int PC_WIDTH = 9,
  parameter int NB_WIDTH = 32,
  parameter int NB_BYTE  = 8
);
  logic                i_load_start;
  logic                i_byte_valid;
  logic [NB_BYTE-1:0]  i_byte;
  logic                i_fetch_en;
  logic                i_stall;
  logic                i_flush;
  logic [PC_WIDTH-1:0] i_address;
  logic [NB_WIDTH-1:0] o_instruction;
  logic                o_ready;
  logic                o_loading;
  logic                o_load_done;
  logic                o_load_full;
  logic [PC_WIDTH:0]   o_word_count;

  modport master (
    output i_load_start, i_byte_valid, i_byte, i_fetch_en, i_stall, i_flush, i_address,
    input  o_instruction, o_ready, o_loading, o_load_done, o_load_full, o_word_count
  );

  modport slave (
    input  i_load_start, i_byte_valid, i_byte, i_fetch_en, i_stall, i_flush, i_address,
    output o_instruction, o_ready, o_loading, o_load_done, o_load_full, o_word_count
  );
endinterface

// File: rtl/instruction_memory_loader.sv
// Program memory with a byte-serial load path and a one-cycle registered
// fetch port (stall holds, flush forces NOP).
//
// state | meaning
// IDLE  | after reset, no program loaded since
// LOAD  | assembling bytes into words, writing at the auto-incrementing pointer
// READY | load terminated (HALT word or memory full), fetch enabled
module instruction_memory_loader #(
  parameter int                  PC_WIDTH  = 9,
  parameter int                  NB_WIDTH  = 32,
  parameter int                  NB_BYTE   = 8,
  parameter logic [NB_WIDTH-1:0] HALT_WORD = {NB_WIDTH{1'b1}},
  parameter logic [NB_WIDTH-1:0] NOP_WORD  = {NB_WIDTH{1'b0}}
) (
  input logic                          i_clk,
  input logic                          i_reset,
  instruction_memory_loader_if.slave   bus
);
  localparam int DEPTH = 2 ** PC_WIDTH;
  localparam int BPW   = NB_WIDTH / NB_BYTE;
  localparam int BC_W  = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

  state_t              state;
  logic [BC_W-1:0]     byte_cnt;
  logic [PC_WIDTH-1:0] ptr;
  logic [NB_WIDTH-1:0] assy;
  logic [NB_WIDTH-1:0] mem [DEPTH];

  logic [NB_WIDTH-1:0] word_next;
  logic                word_last;
  logic                mem_last;
  logic                is_halt;
  logic                wr_en;

  // shift form keeps this legal even when a word is a single byte
  assign word_next = (assy << NB_BYTE) | NB_WIDTH'(bus.i_byte);
  assign word_last = (byte_cnt == BC_W'(BPW - 1));
  assign mem_last  = &ptr;
  assign is_halt   = (word_next == HALT_WORD);
  assign wr_en     = (state == LOAD) && bus.i_byte_valid && word_last && !bus.i_load_start;

  // memory has no reset so a loaded program survives a reset
  always_ff @(posedge i_clk) begin
    if (wr_en)
      mem[ptr] <= word_next;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state             <= IDLE;
      byte_cnt          <= '0;
      ptr               <= '0;
      assy              <= '0;
      bus.o_instruction <= NOP_WORD;
      bus.o_ready       <= 1'b0;
      bus.o_loading     <= 1'b0;
      bus.o_load_done   <= 1'b0;
      bus.o_load_full   <= 1'b0;
      bus.o_word_count  <= '0;
    end else begin
      bus.o_load_done <= 1'b0;

      if (state != READY)
        bus.o_instruction <= NOP_WORD;
      else if (bus.i_flush)
        bus.o_instruction <= NOP_WORD;
      else if (!bus.i_stall && bus.i_fetch_en)
        bus.o_instruction <= mem[bus.i_address];

      if (bus.i_load_start) begin
        // start and restart look the same from any state; a byte in this cycle is dropped
        state            <= LOAD;
        byte_cnt         <= '0;
        ptr              <= '0;
        assy             <= '0;
        bus.o_word_count <= '0;
        bus.o_load_full  <= 1'b0;
        bus.o_loading    <= 1'b1;
        bus.o_ready      <= 1'b0;
      end else if (state == LOAD && bus.i_byte_valid) begin
        assy <= word_next;
        if (word_last) begin
          byte_cnt         <= '0;
          bus.o_word_count <= bus.o_word_count + 1'b1;
          if (!mem_last)
            ptr <= ptr + 1'b1;
          if (is_halt || mem_last) begin
            state           <= READY;
            bus.o_ready     <= 1'b1;
            bus.o_loading   <= 1'b0;
            bus.o_load_done <= 1'b1;
            bus.o_load_full <= !is_halt;
          end
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_instruction_memory_loader.sv
// Bench for instruction_memory_loader: directed scenarios plus randomized
// loads/fetches compared each cycle against a queue-based reference model.
module tb_instruction_memory_loader;
  localparam int PW    = 2;
  localparam int DEPTH = 2 ** PW;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   done_seen = 0;

  instruction_memory_loader_if #(.PC_WIDTH(PW), .NB_WIDTH(32), .NB_BYTE(8)) bus ();

  instruction_memory_loader #(.PC_WIDTH(PW)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: a program is a byte queue grouped four at a time
  logic [31:0] m_mem [DEPTH];
  bit          m_valid [DEPTH];
  logic [7:0]  m_q [$];
  int          m_count;
  bit          m_loading, m_ready, m_full, m_done;
  logic [31:0] m_instr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_count = 0;
    m_loading = 0; m_ready = 0; m_full = 0; m_done = 0;
    m_instr = 32'h0;
  endtask

  task automatic model_edge();
    logic [31:0] w;
    if (rst) begin
      model_reset();
      return;
    end
    m_done = 0;
    if (!m_ready || bus.i_flush) m_instr = 32'h0;
    else if (!bus.i_stall && bus.i_fetch_en) m_instr = m_mem[bus.i_address];
    if (bus.i_load_start) begin
      m_loading = 1; m_ready = 0; m_full = 0; m_count = 0;
      m_q.delete();
    end else if (m_loading && bus.i_byte_valid) begin
      m_q.push_back(bus.i_byte);
      if (m_q.size() == 4) begin
        w = {m_q[0], m_q[1], m_q[2], m_q[3]};
        m_q.delete();
        m_mem[m_count] = w;
        m_valid[m_count] = 1;
        m_count++;
        if (w == HALT || m_count == DEPTH) begin
          m_loading = 0; m_ready = 1; m_done = 1;
          m_full = (w != HALT);
        end
      end
    end
  endtask

  task automatic check_all();
    chk("instr", bus.o_instruction, m_instr);
    chk("ready", 32'(bus.o_ready), 32'(m_ready));
    chk("loading", 32'(bus.o_loading), 32'(m_loading));
    chk("done", 32'(bus.o_load_done), 32'(m_done));
    chk("full", 32'(bus.o_load_full), 32'(m_full));
    chk("count", 32'(bus.o_word_count), 32'(m_count));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    if (bus.o_load_done) done_seen++;
    check_all();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.i_byte_valid = 1'b1;
    bus.i_byte       = b;
    tick();
    bus.i_byte_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8], gap);
  endtask

  task automatic pulse_start();
    bus.i_load_start = 1'b1;
    tick();
    bus.i_load_start = 1'b0;
  endtask

  task automatic fetch(input logic [PW-1:0] a);
    bus.i_fetch_en = 1'b1;
    bus.i_address  = a;
    tick();
    bus.i_fetch_en = 1'b0;
  endtask

  task automatic rand_fetch_ctrl();
    logic [PW-1:0] a;
    a = PW'($urandom_range(DEPTH - 1));
    if (!m_valid[a]) a = '0;
    bus.i_address  = a;
    bus.i_fetch_en = ($urandom_range(1) == 1);
    bus.i_stall    = ($urandom_range(3) == 0);
    bus.i_flush    = ($urandom_range(7) == 0);
  endtask

  initial begin
    logic [31:0] w;
    int nw;
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
    model_reset();
    bus.i_load_start = 0; bus.i_byte_valid = 0; bus.i_byte = '0;
    bus.i_fetch_en = 0; bus.i_stall = 0; bus.i_flush = 0; bus.i_address = '0;
    rst = 1'b1;
    #12;
    check_all();
    rst = 1'b0;
    tick();

    // fetch while idle gives NOP
    fetch(2'd1);
    chk("nr_idle", bus.o_instruction, 32'h0);

    // reset in the middle of a load
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(8'(i + 8'h31), 0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_loading", 32'(bus.o_loading), 32'h0);
    chk("rst_count", 32'(bus.o_word_count), 32'h0);
    check_all();
    tick();
    #3 rst = 1'b0;
    tick();

    // basic load with gaps, fetch attempted during load
    done_seen = 0;
    pulse_start();
    bus.i_fetch_en = 1'b1;
    send_word(32'h2001_0005, 1);
    chk("nr_load", bus.o_instruction, 32'h0);
    bus.i_fetch_en = 1'b0;
    send_word(32'h2002_0007, 2);
    send_word(HALT, 1);
    tick();
    chk("basic_done_cnt", done_seen, 1);
    chk("basic_count", 32'(bus.o_word_count), 32'd3);
    chk("basic_ready", 32'(bus.o_ready), 32'd1);
    fetch(2'd0); chk("fetch0", bus.o_instruction, 32'h2001_0005);
    fetch(2'd1); chk("fetch1", bus.o_instruction, 32'h2002_0007);
    fetch(2'd2); chk("fetch2", bus.o_instruction, 32'hFFFF_FFFF);

    // stall holds, flush beats stall
    fetch(2'd1);
    bus.i_fetch_en = 1'b1; bus.i_stall = 1'b1; bus.i_address = 2'd2;
    tick();
    chk("stall_hold", bus.o_instruction, 32'h2002_0007);
    bus.i_flush = 1'b1;
    tick();
    chk("flush", bus.o_instruction, 32'h0);
    bus.i_flush = 1'b0; bus.i_stall = 1'b0; bus.i_fetch_en = 1'b0;
    tick();

    // full memory, then surplus bytes are ignored
    done_seen = 0;
    pulse_start();
    send_word(32'h1122_3344, 0);
    send_word(32'h5566_7788, 1);
    send_word(32'h99AA_BBCC, 0);
    send_word(32'h0DDE_EFF0, 1);
    for (int i = 0; i < 8; i++) send_byte(8'hFF, 0);
    chk("full_flag", 32'(bus.o_load_full), 32'd1);
    chk("full_count", 32'(bus.o_word_count), 32'd4);
    chk("full_done_cnt", done_seen, 1);
    fetch(2'd0); chk("full_m0", bus.o_instruction, 32'h1122_3344);
    fetch(2'd1); chk("full_m1", bus.o_instruction, 32'h5566_7788);
    fetch(2'd2); chk("full_m2", bus.o_instruction, 32'h99AA_BBCC);
    fetch(2'd3); chk("full_m3", bus.o_instruction, 32'h0DDE_EFF0);

    // restart mid-word, with a byte in the restart cycle
    pulse_start();
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 1);
    bus.i_load_start = 1'b1; bus.i_byte_valid = 1'b1; bus.i_byte = 8'hCC;
    tick();
    bus.i_load_start = 1'b0; bus.i_byte_valid = 1'b0;
    send_word(32'h1234_5678, 0);
    send_word(HALT, 0);
    chk("restart_count", 32'(bus.o_word_count), 32'd2);
    chk("restart_full", 32'(bus.o_load_full), 32'd0);
    fetch(2'd0); chk("restart_m0", bus.o_instruction, 32'h1234_5678);
    fetch(2'd1); chk("restart_m1", bus.o_instruction, HALT);

    // randomized loads, restarts and fetch traffic
    for (int r = 0; r < 40; r++) begin
      rand_fetch_ctrl();
      pulse_start();
      nw = $urandom_range(5, 1);
      for (int wi = 0; wi < nw; wi++) begin
        w = $urandom;
        if (wi == nw - 1 && $urandom_range(1) == 1) w = HALT;
        for (int k = 3; k >= 0; k--) begin
          rand_fetch_ctrl();
          if ($urandom_range(15) == 0) bus.i_load_start = 1'b1;
          send_byte(w[8*k +: 8], $urandom_range(2));
          bus.i_load_start = 1'b0;
        end
      end
      for (int c = 0; c < 12; c++) begin
        rand_fetch_ctrl();
        bus.i_byte_valid = ($urandom_range(3) == 0);
        bus.i_byte = 8'($urandom);
        tick();
      end
      bus.i_byte_valid = 1'b0;
    end
    bus.i_fetch_en = 0; bus.i_stall = 0; bus.i_flush = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
